// File: rtl/ct_loader_if.sv
// ct_loader_if
//   Valid/ready byte stream carrying length-prefixed ciphertext into the loader.
//   Signals:
//     in_valid  source -> loader  byte on in_data is valid
//     in_ready  loader -> source  loader accepts the byte this cycle
//     in_data   source -> loader  stream byte (first byte of a message is the length)
//   Modports:
//     master  stream source
//     slave   loader side
interface ct_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ct_loader.sv
// ct_loader
//   Front end of the dual-core ARC4 key cracker. Loads a length-prefixed
//   ciphertext from a byte stream into ct_mem (addr 0 = length L, addr 1..L =
//   payload), hands the memory port to the cracker, pulses its start, times the
//   run and latches the key result.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stream          ct_loader_if.slave byte stream (in_valid/in_ready/in_data)
//   clear           from DONE, return to loading the next message
//   mem_own         1 while the loader drives the ct_mem port
//   ct_addr         ct_mem address, ct_wrdata write data, ct_wren write enable
//   crk_en          one-cycle cracker start pulse
//   crk_rdy         cracker ready (low while busy)
//   crk_key         cracker key result, crk_key_vld key found
//   done            result registers valid
//   res_key         latched key, res_vld latched key_valid
//   res_cycles      cycles from crk_en pulse to crk_rdy rising (saturating)
//
// state     | meaning
// ----------+-------------------------------------------------------
// LOAD_LEN  | waiting for the length byte, written to addr 0
// LOAD_DATA | writing payload bytes to addr 1..L
// WAIT_RDY  | memory released, waiting for the cracker to be idle
// START     | crk_en high for this single cycle, counter cleared
// WAIT_BUSY | waiting for the cracker to drop crk_rdy
// WAIT_DONE | cracker running, counting cycles until crk_rdy returns
// DONE      | results valid, waiting for clear
module ct_loader #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ct_loader_if.slave       stream,
    input  logic             clear,
    output logic             mem_own,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren,
    output logic             crk_en,
    input  logic             crk_rdy,
    input  logic [23:0]      crk_key,
    input  logic             crk_key_vld,
    output logic             done,
    output logic [23:0]      res_key,
    output logic             res_vld,
    output logic [CNT_W-1:0] res_cycles
);

    typedef enum logic [2:0] {
        S_LOAD_LEN,
        S_LOAD_DATA,
        S_WAIT_RDY,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    // 9 bits so that L=255 finishes at addr 255 without the count wrapping to 0
    logic [8:0]       cnt;
    logic [7:0]       len;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] cyc_inc;
    logic             loading;
    logic             accept;

    localparam logic [CNT_W-1:0] CYC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign cyc_inc   = (cyc == {CNT_W{1'b1}}) ? cyc : cyc + CYC_ONE;
    assign accept    = stream.in_valid & loading;

    assign stream.in_ready = loading;
    assign ct_wren   = accept;
    assign ct_addr   = cnt[7:0];
    assign ct_wrdata = stream.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        loading   = 1'b0;
        mem_own   = 1'b0;
        crk_en    = 1'b0;
        case (state)
            S_LOAD_LEN: begin
                loading = 1'b1;
                mem_own = 1'b1;
                if (stream.in_valid) begin
                    state_nxt = (stream.in_data == 8'd0) ? S_WAIT_RDY : S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: begin
                loading = 1'b1;
                mem_own = 1'b1;
                if (stream.in_valid && (cnt == {1'b0, len})) begin
                    state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (crk_rdy) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                crk_en    = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // no re-pulse: a cracker that never drops crk_rdy holds us here
                if (!crk_rdy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (crk_rdy) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_nxt = S_LOAD_LEN;
                end
            end
            default: state_nxt = S_LOAD_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 9'd0;
            len        <= 8'd0;
            cyc        <= '0;
            done       <= 1'b0;
            res_key    <= 24'd0;
            res_vld    <= 1'b0;
            res_cycles <= '0;
        end else begin
            case (state)
                S_LOAD_LEN: begin
                    if (accept) begin
                        len <= stream.in_data;
                        cnt <= 9'd1;
                    end
                end
                S_LOAD_DATA: begin
                    if (accept) begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_START: begin
                    cyc <= '0;
                end
                S_WAIT_BUSY: begin
                    cyc <= cyc_inc;
                end
                S_WAIT_DONE: begin
                    cyc <= cyc_inc;
                    // the cycle that sees crk_rdy high is counted too, so the
                    // latched value spans the crk_en cycle through the rising edge
                    if (crk_rdy) begin
                        res_key    <= crk_key;
                        res_vld    <= crk_key_vld;
                        res_cycles <= cyc_inc;
                        done       <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        done <= 1'b0;
                        cnt  <= 9'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
module tb_ct_loader;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             mem_own;
    logic [7:0]       ct_addr;
    logic [7:0]       ct_wrdata;
    logic             ct_wren;
    logic             crk_en;
    logic             crk_rdy;
    logic [23:0]      crk_key;
    logic             crk_key_vld;
    logic             done;
    logic [23:0]      res_key;
    logic             res_vld;
    logic [CNT_W-1:0] res_cycles;

    ct_loader_if sif ();

    ct_loader #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream      (sif),
        .clear       (clear),
        .mem_own     (mem_own),
        .ct_addr     (ct_addr),
        .ct_wrdata   (ct_wrdata),
        .ct_wren     (ct_wren),
        .crk_en      (crk_en),
        .crk_rdy     (crk_rdy),
        .crk_key     (crk_key),
        .crk_key_vld (crk_key_vld),
        .done        (done),
        .res_key     (res_key),
        .res_vld     (res_vld),
        .res_cycles  (res_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc_no = 0;
    always @(negedge clk) cyc_no++;

    // observed ct_mem writes
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    always @(posedge clk) begin
        if (ct_wren) begin
            wa_q.push_back(ct_addr);
            wd_q.push_back(ct_wrdata);
        end
    end

    // message being sent, and cracker behaviour for the current run
    logic [7:0] msg[$];
    int         busy_len;
    logic [23:0] key_val;
    logic        vld_val;
    int          en_count = 0;
    int          en_cyc   = 0;
    int          rise_cyc = 0;

    // cracker model: drops ready right after the start pulse, stays busy for
    // busy_len cycles, then returns ready with the result on its outputs
    initial begin
        forever begin
            @(posedge clk);
            if (crk_en === 1'b1) begin
                en_count++;
                en_cyc = cyc_no;
                #1 crk_rdy = 1'b0;
                repeat (busy_len) @(posedge clk);
                rise_cyc = cyc_no;
                #1;
                crk_key     = key_val;
                crk_key_vld = vld_val;
                crk_rdy     = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stall_mode: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random
    task automatic send_msg(input int nbytes, input int stall_mode);
        int  idx = 0;
        int  guard = 0;
        bit  drive;
        while (idx < nbytes && guard < 4000) begin
            @(negedge clk);
            guard++;
            case (stall_mode)
                0:       drive = 1'b1;
                1:       drive = (guard % 2) == 1;
                default: drive = ($urandom_range(0, 1) == 1);
            endcase
            sif.in_valid = drive;
            sif.in_data  = drive ? msg[idx] : 8'($urandom);
            if (drive && sif.in_ready === 1'b1) idx++;
        end
        if (idx < nbytes) check("send_timeout", 64'(idx), 64'(nbytes));
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int nbytes);
        check({tag, "_wr_count"}, 64'(wa_q.size()), 64'(nbytes));
        for (int i = 0; i < nbytes && i < wa_q.size(); i++) begin
            check({tag, "_wr_addr"}, 64'(wa_q[i]), 64'(i));
            check({tag, "_wr_data"}, 64'(wd_q[i]), 64'(msg[i]));
        end
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (done !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic build_msg(input int len);
        msg.delete();
        msg.push_back(8'(len));
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic run_msg(input string tag, input int stall_mode, input int busy,
                           input logic [23:0] key, input logic vld, input bit poke_clear);
        int en0;
        int g;
        wa_q.delete();
        wd_q.delete();
        en0      = en_count;
        busy_len = busy;
        key_val  = key;
        vld_val  = vld;
        send_msg(msg.size(), stall_mode);
        check({tag, "_in_ready_drop"}, 64'(sif.in_ready), 64'd0);
        check({tag, "_mem_released"}, 64'(mem_own), 64'd0);
        check_writes(tag, msg.size());
        if (poke_clear) begin
            g = 0;
            while (crk_rdy !== 1'b0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            check({tag, "_clear_ignored"}, 64'(done), 64'd0);
        end
        wait_done(tag);
        check({tag, "_en_pulses"}, 64'(en_count - en0), 64'd1);
        check({tag, "_res_key"}, 64'(res_key), 64'(key));
        check({tag, "_res_vld"}, 64'(res_vld), 64'(vld));
        check({tag, "_res_cycles"}, 64'(res_cycles), 64'(rise_cyc - en_cyc + 1));
        check({tag, "_done_mem_own"}, 64'(mem_own), 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check({tag, "_clr_in_ready"}, 64'(sif.in_ready), 64'd1);
        check({tag, "_clr_done"}, 64'(done), 64'd0);
        check({tag, "_clr_res_held"}, 64'(res_vld), 64'(vld));
    endtask

    initial begin
        int en_before;
        rst_n        = 1'b0;
        clear        = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'd0;
        crk_rdy      = 1'b1;
        crk_key      = 24'd0;
        crk_key_vld  = 1'b0;
        busy_len     = 1;
        key_val      = 24'd0;
        vld_val      = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 64'(sif.in_ready), 64'd1);
        check("rst_mem_own", 64'(mem_own), 64'd1);
        check("rst_ct_wren", 64'(ct_wren), 64'd0);
        check("rst_crk_en", 64'(crk_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res_key", 64'(res_key), 64'd0);
        check("rst_res_vld", 64'(res_vld), 64'd0);
        check("rst_res_cycles", 64'(res_cycles), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // L=3, no stalls, 100-cycle crack with a key found
        msg = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
        run_msg("l3", 0, 100, 24'h000018, 1'b1, 1'b0);
        check("l3_cycles_101", 64'(res_cycles), 64'd101);

        // L=5 with alternating valid, no key found, clear poked while busy
        build_msg(5);
        run_msg("l5", 1, $urandom_range(5, 40), 24'($urandom), 1'b0, 1'b1);

        // L=0: only the length byte is written
        msg = '{8'h00};
        run_msg("l0", 0, $urandom_range(1, 20), 24'($urandom), 1'b1, 1'b0);

        // random length, random stalls
        build_msg($urandom_range(1, 20));
        run_msg("rnd", 2, $urandom_range(1, 60), 24'($urandom), 1'($urandom), 1'b0);

        // L=255: full address range, last write at 255
        build_msg(255);
        run_msg("l255", 2, $urandom_range(1, 30), 24'($urandom), 1'b1, 1'b0);
        check("l255_last_addr", 64'(wa_q[wa_q.size()-1]), 64'd255);

        // reset during LOAD_DATA once cnt has reached 40
        build_msg(255);
        wa_q.delete();
        wd_q.delete();
        en_before = en_count;
        send_msg(40, 2);
        check("abort_wr_count", 64'(wa_q.size()), 64'd40);
        check("abort_last_addr", 64'(wa_q[wa_q.size()-1]), 64'd39);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(sif.in_ready), 64'd1);
        check("abort_ct_wren", 64'(ct_wren), 64'd0);
        check("abort_mem_own", 64'(mem_own), 64'd1);
        check("abort_res_cycles", 64'(res_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_crk_en", 64'(en_count - en_before), 64'd0);
        check("abort_done", 64'(done), 64'd0);

        // next byte after the abort is a fresh length
        build_msg(2);
        run_msg("post", 0, $urandom_range(1, 20), 24'($urandom), 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
